// File: rtl/spi_m_gen.sv
// SPI master: configurable width, mode, bit order, SCLK divider and chip selects,
// with CS setup/hold timing and optional CS-keep for back-to-back bursts.
module spi_m_gen #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_HALF  = 2,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned N_CS      = 1,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  localparam int unsigned CS_W     = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_keep,
  input  logic [DATA_W-1:0] writ_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              rdy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [N_CS-1:0]   cs_n
);

  localparam int unsigned HP_W    = $clog2(2 * DATA_W);
  localparam int unsigned DIV_W   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_HALF - 1);
  localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(2 * DATA_W - 1);
  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(CS_HOLD - 1);
  localparam logic [CS_W:0]    N_CS_L    = (CS_W + 1)'(N_CS);
  localparam logic             SCLK_IDLE = (CPOL != 0);
  localparam logic             SAMPLE_LEAD = (CPHA == 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  read_data_q, read_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [N_CS-1:0]    cs_n_q, cs_n_d;
  logic [CS_W-1:0]    sel_q, sel_d;
  logic               keep_q, keep_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               miso_s1_q, miso_s1_d;
  logic               miso_s2_q, miso_s2_d;
  logic               leading;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  function automatic logic [N_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [N_CS-1:0] v;
    v = '1;
    for (int unsigned i = 0; i < N_CS; i++) begin
      if (sel == CS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    sel_d       = sel_q;
    keep_d      = keep_q;
    div_d       = div_q;
    hp_d        = hp_q;
    tmr_d       = tmr_q;
    miso_s1_d   = miso;
    miso_s2_d   = miso_s1_q;
    leading     = ~hp_q[0];

    case (state_q)
      IDLE: begin
        if (start && ({1'b0, cs_sel} < N_CS_L)) begin
          sel_d  = cs_sel;
          keep_d = cs_keep;
          if (CPHA == 0) begin
            mosi_d = first_bit(writ_data);
            tx_d   = shift_tx(writ_data);
          end else begin
            tx_d = writ_data;
          end
          // A CS still held from a kept burst either continues directly or
          // must be released for one cycle before another CS is selected.
          if (cs_n_q == '1) begin
            state_d = SETUP;
            tmr_d   = SETUP_LD;
            cs_n_d  = cs_decode(cs_sel);
          end else if (cs_n_q == cs_decode(cs_sel)) begin
            state_d = SHIFT;
            div_d   = '0;
            hp_d    = '0;
          end else begin
            state_d = GAP;
            cs_n_d  = '1;
          end
        end
      end

      GAP: begin
        state_d = SETUP;
        tmr_d   = SETUP_LD;
        cs_n_d  = cs_decode(sel_q);
      end

      SETUP: begin
        if (tmr_q == '0) begin
          state_d = SHIFT;
          div_d   = '0;
          hp_d    = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          hp_d   = hp_q + 1'b1;
          if (leading == SAMPLE_LEAD) begin
            rx_d = shift_rx(rx_q, miso_s2_q);
          end else if ((CPHA != 0) || (hp_q != HP_LAST)) begin
            // CPHA=0 keeps the last bit on mosi through HOLD
            mosi_d = first_bit(tx_q);
            tx_d   = shift_tx(tx_q);
          end
          if (hp_q == HP_LAST) begin
            state_d = HOLD;
            tmr_d   = HOLD_LD;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      HOLD: begin
        if (tmr_q == '0) begin
          state_d     = IDLE;
          rd_valid_d  = 1'b1;
          read_data_d = rx_q;
          if (!keep_q) cs_n_d = '1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = '1;
        sclk_d  = SCLK_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      sclk_q      <= SCLK_IDLE;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      sel_q       <= '0;
      keep_q      <= 1'b0;
      div_q       <= '0;
      hp_q        <= '0;
      tmr_q       <= '0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      sel_q       <= sel_d;
      keep_q      <= keep_d;
      div_q       <= div_d;
      hp_q        <= hp_d;
      tmr_q       <= tmr_d;
      miso_s1_q   <= miso_s1_d;
      miso_s2_q   <= miso_s2_d;
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign rdy       = (state_q == IDLE);
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;

endmodule
